// File: rtl/zl_ts_packet_scheduler_pkg.sv
// Shared constants and state encodings for the TS packet scheduler and
// related multiplexer blocks.
package zl_ts_packet_scheduler_pkg;

    localparam int          TS_PKT_LEN   = 188;
    localparam logic [7:0]  TS_SYNC      = 8'h47;
    localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;
    localparam logic [7:0]  TS_NULL_HDR3 = 8'h10;
    localparam logic [7:0]  TS_STUFF     = 8'hFF;

    typedef enum logic [1:0] {
        S_SEL  = 2'd0,
        S_USER = 2'd1,
        S_NULL = 2'd2,
        S_DROP = 2'd3
    } sched_state_t;

endpackage

// File: rtl/zl_ts_null_gen.sv
// Null TS packet byte generator: maps a byte index within the packet to the
// null-packet byte (4-byte header, then 0xFF stuffing). Purely combinational.
module zl_ts_null_gen
    import zl_ts_packet_scheduler_pkg::*;
#(
    parameter int          CNT_W     = 8,
    parameter logic [7:0]  Sync_byte = TS_SYNC,
    parameter logic [12:0] Null_pid  = TS_NULL_PID
) (
    input  logic [CNT_W-1:0] byte_cnt,
    output logic [7:0]       data
);

    // Header lookup with stuffing for every payload byte; CC is always 0.
    always_comb begin
        data = TS_STUFF;
        case (byte_cnt)
            CNT_W'(0): data = Sync_byte;
            CNT_W'(1): data = {3'b000, Null_pid[12:8]};
            CNT_W'(2): data = Null_pid[7:0];
            CNT_W'(3): data = TS_NULL_HDR3;
            default:   data = TS_STUFF;
        endcase
    end

endmodule

// File: rtl/zl_ts_packet_scheduler.sv
// Packet-level scheduler ahead of the DVB-S core: per 188-byte slot it
// forwards a whole user packet, inserts a null packet, or drops one
// misaligned user byte while hunting for sync.
module zl_ts_packet_scheduler
    import zl_ts_packet_scheduler_pkg::*;
#(
    parameter int          Pkt_len   = TS_PKT_LEN,
    parameter logic [7:0]  Sync_byte = TS_SYNC,
    parameter logic [12:0] Null_pid  = TS_NULL_PID,
    parameter int          Cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 user_pkt_ready,
    input  logic [7:0]           data_in,
    input  logic                 data_in_req,
    output logic                 data_in_ack,
    output logic [7:0]           data_out,
    output logic                 data_out_req,
    input  logic                 data_out_ack,
    output logic                 busy,
    output logic                 sync_err,
    output logic [Cnt_width-1:0] user_pkt_cnt,
    output logic [Cnt_width-1:0] null_pkt_cnt
);

    localparam int            CW       = $clog2(Pkt_len);
    localparam logic [CW-1:0] LAST_IDX = CW'(Pkt_len - 1);

    sched_state_t  state;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    null_byte;
    logic          out_xfer;
    logic          in_xfer;

    zl_ts_null_gen #(
        .CNT_W     (CW),
        .Sync_byte (Sync_byte),
        .Null_pid  (Null_pid)
    ) u_null_gen (
        .byte_cnt (byte_cnt),
        .data     (null_byte)
    );

    assign out_xfer = data_out_req && data_out_ack;
    assign in_xfer  = data_in_req && data_in_ack;
    assign busy     = (state == S_USER) || (state == S_NULL);

    // Output/handshake steering: USER is a zero-latency pass-through, NULL
    // sources the generator, DROP swallows one byte and flags it.
    always_comb begin
        data_out     = '0;
        data_out_req = 1'b0;
        data_in_ack  = 1'b0;
        sync_err     = 1'b0;
        case (state)
            S_USER: begin
                data_out     = data_in;
                data_out_req = data_in_req;
                data_in_ack  = data_out_ack;
            end
            S_NULL: begin
                data_out     = null_byte;
                data_out_req = 1'b1;
            end
            S_DROP: begin
                data_in_ack = 1'b1;
                sync_err    = data_in_req;
            end
            default: ;
        endcase
    end

    // Packet FSM: one SEL decision cycle per slot, byte counting on output
    // transfers, statistics bumped on the last byte of each packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_SEL;
            byte_cnt     <= '0;
            user_pkt_cnt <= '0;
            null_pkt_cnt <= '0;
        end else begin
            case (state)
                S_SEL: begin
                    if (en) begin
                        byte_cnt <= '0;
                        if (user_pkt_ready && data_in_req && (data_in == Sync_byte))
                            state <= S_USER;
                        else if (user_pkt_ready && data_in_req)
                            state <= S_DROP;
                        else
                            state <= S_NULL;
                    end
                end
                S_USER, S_NULL: begin
                    if (out_xfer) begin
                        if (byte_cnt == LAST_IDX) begin
                            byte_cnt <= '0;
                            state    <= S_SEL;
                            if (state == S_USER)
                                user_pkt_cnt <= user_pkt_cnt + Cnt_width'(1);
                            else
                                null_pkt_cnt <= null_pkt_cnt + Cnt_width'(1);
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                end
                S_DROP: begin
                    if (in_xfer)
                        state <= S_SEL;
                end
                default: state <= S_SEL;
            endcase
        end
    end

endmodule

// File: doc/zl_ts_packet_scheduler.md
Name: zl_ts_packet_scheduler

Overview:
- Packet-level scheduler in front of the DVB-S core input.
- Selects, per 188-byte slot, either a complete user TS packet from the upstream buffer or an internally generated null packet (PID 0x1FFF), so the core never starves mid-packet.
- Drops misaligned user bytes until sync (0x47) is found.
- Exports packet and error statistics.

Parameters:
- Pkt_len, 188, bytes per TS packet, including the sync byte.
- Sync_byte, 8'h47, required first byte of every packet.
- Null_pid, 13'h1FFF, PID written into generated null packets.
- Cnt_width, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- en  in  1  scheduler enable, sampled only at packet boundaries.
- user_pkt_ready  in  1  upstream buffer holds at least Pkt_len bytes.
- data_in  in  8  user byte.
- data_in_req  in  1  user byte valid.
- data_in_ack  out  1  user byte accepted.
- data_out  out  8  byte to the DVB-S core.
- data_out_req  out  1  output byte valid.
- data_out_ack  in  1  core accepts the byte.
- busy  out  1  a packet is in progress.
- sync_err  out  1  one-cycle pulse per dropped user byte.
- user_pkt_cnt  out  Cnt_width  user packets forwarded (wraps).
- null_pkt_cnt  out  Cnt_width  null packets inserted (wraps).

Behaviour:
- Handshake: a transfer occurs on any cycle with req && ack. The producer holds req and data stable until ack. The ack may be combinational.
- Reset: state=SEL; byte_cnt=0; all counters 0. Outputs after reset: data_out_req=0, data_in_ack=0, busy=0, sync_err=0, data_out=0 (don't-care while req=0).
- FSM states: SEL, USER, NULL, DROP.
- SEL (no output, one cycle per packet decision):
  - If !en: stay in SEL.
  - Else if user_pkt_ready && data_in_req && data_in==Sync_byte: go to USER.
  - Else if user_pkt_ready && data_in_req: go to DROP.
  - Else: go to NULL.
  - byte_cnt is cleared on every exit from SEL.
- USER: combinational pass-through.
  - data_out=data_in; data_out_req=data_in_req; data_in_ack=data_out_ack.
  - byte_cnt increments on each transfer.
  - On the transfer with byte_cnt==Pkt_len-1: user_pkt_cnt++, go to SEL.
  - Zero added latency. Upstream stalls propagate.
- NULL: data_out_req=1 and data_in_ack=0.
  - Byte sequence: 0x47, {3'b000,Null_pid[12:8]}, Null_pid[7:0], 0x10, then 0xFF for every remaining byte.
  - On the last byte transferred: null_pkt_cnt++, go to SEL.
  - The continuity counter is always 0, which is legal for null packets.
- DROP: data_in_ack=1, data_out_req=0.
  - On the data_in transfer, pulse sync_err for one cycle and return to SEL.
  - Exactly one byte is consumed per visit, so resync is a repeated SEL/DROP loop.
- busy=1 in USER and NULL.
- A packet in progress always completes. en deasserting mid-packet has no effect until SEL.
- user_pkt_ready deasserting mid-USER packet causes no abort; the scheduler waits on data_in_req.
- byte_cnt width is clog2(Pkt_len). It never exceeds Pkt_len-1.
- Counters wrap modulo 2^Cnt_width.
- rst asserted mid-packet aborts immediately to SEL. The partial packet is lost; downstream resynchronises on 0x47.
- data_out_ack held low leaves the FSM and byte_cnt frozen, with data_out stable.

Decomposition:
- Shared package: constants TS_PKT_LEN=188, TS_SYNC=8'h47, TS_NULL_PID=13'h1FFF, TS_NULL_HDR3=8'h10, TS_STUFF=8'hFF.
- Shared package: state encodings SEL/USER/NULL/DROP.
- One natural sub-module, zl_ts_null_gen: byte_cnt → null packet byte lookup (header mux plus 0xFF stuffing). Purely combinational and reusable by later multiplexer blocks.

Test Plan:
1. en=1, user_pkt_ready=0, data_out_ack=1 always.
   - Output: 0x47, 0x1F, 0xFF, 0x10, then 184×0xFF, then one idle cycle, repeating.
   - After 3 packets: null_pkt_cnt=3, user_pkt_cnt=0.
2. Upstream supplies a 188-byte packet (0x47, 0x00, 0x21, ..., incrementing), with user_pkt_ready=1.
   - Output is bit-exact with the input at zero latency.
   - user_pkt_cnt=1. data_in_ack mirrors data_out_ack.
3. Upstream presents 0x12, 0x34, then an aligned packet.
   - sync_err pulses twice; no output during the drops.
   - The next packet forwarded starts with 0x47.
4. Random data_out_ack (50%) during both USER and NULL packets.
   - No byte lost or duplicated; data_out stable while req && !ack.
   - Byte count per packet is 188.
5. Deassert en at byte 100 of a null packet.
   - The packet completes (188 bytes), then output idles in SEL.
   - Re-asserting en resumes at a packet start.
6. Assert rst at byte 50 of a user packet.
   - Next cycle: data_out_req=0, counters=0.
   - After release, the first output packet begins with 0x47.
